// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one 32-bit read at a time and hands
// each fetched word plus its PC to decode over a valid/ready link.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_FLUSH,
        S_HOLD,
        S_ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;

    logic        redirect_bad;
    logic        redirect_ok;
    logic [7:0]  wait_cnt_inc;
    logic        timeout_hit;

    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_ok  = redirect_valid && !redirect_bad;
    assign wait_cnt_inc = wait_cnt + 8'd1;
    // A zero limit disables the watchdog entirely.
    assign timeout_hit  = (TIMEOUT_LIMIT != 8'd0) && (wait_cnt_inc == TIMEOUT_LIMIT);

    // Handshake valids are held low while reset is asserted, whatever the state.
    assign mem_req_valid = !rst && (state == S_REQ);
    assign inst_valid    = !rst && (state == S_HOLD);
    assign mem_req_addr  = pc;
    assign fetch_err     = (state == S_ERR);

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values; blocking here would let later lines see already-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            inst     <= '0;
            inst_pc  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_bad) begin
                        state <= S_ERR;
                    end else begin
                        if (redirect_ok) pc <= redirect_pc;
                        if (mem_req_ready) begin
                            wait_cnt <= '0;
                            state    <= redirect_ok ? S_FLUSH : S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (redirect_bad) begin
                        state <= S_ERR;
                    end else if (redirect_ok) begin
                        pc <= redirect_pc;
                        if (mem_rsp_valid) begin
                            state <= S_REQ;
                        end else begin
                            wait_cnt <= '0;
                            state    <= S_FLUSH;
                        end
                    end else if (mem_rsp_valid) begin
                        inst    <= mem_rsp_data;
                        inst_pc <= pc;
                        state   <= S_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (timeout_hit) state <= S_ERR;
                    end
                end
                S_FLUSH: begin
                    // The in-flight response belongs to a stale PC and is discarded.
                    if (redirect_bad) begin
                        state <= S_ERR;
                    end else begin
                        if (redirect_ok) pc <= redirect_pc;
                        if (mem_rsp_valid) begin
                            state <= S_REQ;
                        end else begin
                            wait_cnt <= wait_cnt_inc;
                            if (timeout_hit) state <= S_ERR;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_bad) begin
                        state <= S_ERR;
                    end else if (redirect_ok) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end else if (inst_ready) begin
                        pc    <= pc + 32'd4;
                        state <= S_REQ;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a transaction-level reference model is compared against
// every DUT output each cycle, plus literal expectations at key points of each scenario.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TIMEOUT  = 4;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    ifu_fetch #(
        .RESET_PC      (RESET_PC),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_err     (fetch_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a read is either being offered, in flight (possibly doomed),
    // or its word is parked for decode; errors are sticky until reset.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    bit          m_pending;
    bit          m_doomed;
    bit          m_hold;
    bit          m_err;
    int          m_wait;

    task automatic model_step();
        if (rst) begin
            m_pc = RESET_PC; m_inst = '0; m_inst_pc = '0;
            m_pending = 0; m_doomed = 0; m_hold = 0; m_err = 0; m_wait = 0;
        end else if (!m_err) begin
            if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
                m_err = 1;
            end else if (m_hold) begin
                if (redirect_valid) begin
                    m_pc = redirect_pc; m_hold = 0;
                end else if (inst_ready) begin
                    m_pc = m_pc + 32'd4; m_hold = 0;
                end
            end else if (m_pending) begin
                if (mem_rsp_valid) begin
                    m_pending = 0;
                    if (!m_doomed && !redirect_valid) begin
                        m_inst = mem_rsp_data; m_inst_pc = m_pc; m_hold = 1;
                    end
                    m_doomed = 0;
                    if (redirect_valid) m_pc = redirect_pc;
                end else if (redirect_valid && !m_doomed) begin
                    m_pc = redirect_pc; m_doomed = 1; m_wait = 0;
                end else begin
                    if (redirect_valid) m_pc = redirect_pc;
                    m_wait++;
                    if (m_wait == TIMEOUT) m_err = 1;
                end
            end else begin
                if (mem_req_ready) begin
                    m_pending = 1; m_doomed = redirect_valid; m_wait = 0;
                end
                if (redirect_valid) m_pc = redirect_pc;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every output on the falling edge, away from the DUT's active edge.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cyc_mem_req_valid", 32'(mem_req_valid), 32'(!rst && !m_err && !m_pending && !m_hold));
            check("cyc_mem_req_addr", mem_req_addr, m_pc);
            check("cyc_inst_valid", 32'(inst_valid), 32'(!rst && !m_err && m_hold));
            check("cyc_inst", inst, m_inst);
            check("cyc_inst_pc", inst_pc, m_inst_pc);
            check("cyc_fetch_err", 32'(fetch_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        cmp_en = 1;
        #1;
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        tick();

        // Basic fetch, then a five-cycle decode stall.
        rst = 1'b0; mem_req_ready = 1'b1; #1;
        check("t1_req_valid", 32'(mem_req_valid), 32'd1);
        check("t1_addr", mem_req_addr, 32'h8000_0000);
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413; #1;
        check("t1_no_req_in_wait", 32'(mem_req_valid), 32'd0);
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("t1_inst_valid", 32'(inst_valid), 32'd1);
        check("t1_inst", inst, 32'h0000_0413);
        check("t1_inst_pc", inst_pc, 32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            check("t2_stall_valid", 32'(inst_valid), 32'd1);
            check("t2_stall_inst", inst, 32'h0000_0413);
            check("t2_stall_noreq", 32'(mem_req_valid), 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0; #1;
        check("t1_next_addr", mem_req_addr, 32'h8000_0004);

        // Redirect while waiting; the late response must be dropped.
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("t3_no_inst", 32'(inst_valid), 32'd0);
        check("t3_req_valid", 32'(mem_req_valid), 32'd1);
        check("t3_addr", mem_req_addr, 32'h8000_0100);

        // Redirect beats inst_ready in HOLD.
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0093;
        tick();
        mem_rsp_valid = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; #1;
        check("t4_inst_pc", inst_pc, 32'h8000_0100);
        tick();
        inst_ready = 1'b0; redirect_valid = 1'b0; #1;
        check("t4_addr", mem_req_addr, 32'h8000_0200);
        check("t4_no_inst", 32'(inst_valid), 32'd0);

        // Redirect in REQ without handshake, then PC wrap-around.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; #1;
        check("wrap_addr", mem_req_addr, 32'hFFFF_FFFC);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
        tick();
        mem_rsp_valid = 1'b0; inst_ready = 1'b1; #1;
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        inst_ready = 1'b0; #1;
        check("wrap_next_addr", mem_req_addr, 32'h0000_0000);
        check("wrap_no_err", 32'(fetch_err), 32'd0);

        // Redirect together with an accepted request: that response is discarded.
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; mem_req_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("flush_no_inst", 32'(inst_valid), 32'd0);
        check("flush_addr", mem_req_addr, 32'h8000_0300);

        // Memory timeout with no response.
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick(); tick(); tick(); #1;
        check("t6_err_before", 32'(fetch_err), 32'd0);
        tick(); #1;
        check("t6_err_after", 32'(fetch_err), 32'd1);
        check("t6_no_req", 32'(mem_req_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("t6_rst_clears", 32'(fetch_err), 32'd0);

        // Misaligned redirect: sticky error, pc untouched, requests stop.
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0; mem_req_ready = 1'b1; #1;
        check("t5_err", 32'(fetch_err), 32'd1);
        check("t5_pc_kept", mem_req_addr, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t5_no_req", 32'(mem_req_valid), 32'd0);
        end
        mem_req_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("t5_rst_clears", 32'(fetch_err), 32'd0);
        check("t5_req_again", 32'(mem_req_valid), 32'd1);

        // Reset mid-request; the late response arriving in REQ is ignored.
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; rst = 1'b1;
        tick(); #1;
        check("rst_mid_noreq", 32'(mem_req_valid), 32'd0);
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("late_rsp_no_inst", 32'(inst_valid), 32'd0);
        check("late_rsp_addr", mem_req_addr, 32'h8000_0000);
        tick(); tick();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
